// File: rtl/adder_ctrl_pkg.sv
// Shared constants and types for the round-robin adder arbiter.
// The adder width is fixed at 32. The FSM has two states: IDLE (response register empty) and FULL.
package adder_ctrl_pkg;

    localparam int W            = 32;
    localparam int NREQ_DEFAULT = 4;
    localparam int IDW_DEFAULT  = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         of;
        logic         eq;
    } add_result_t;

endpackage

// File: rtl/adder.sv
// Purely combinational 32-bit adder.
// Outputs: the sum, the carry-out, signed overflow, and an a==b compare.
module adder
    import adder_ctrl_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         cary,
    output logic         of,
    output logic         eq
);

    logic [W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        s        = wide_sum[W-1:0];
        cary     = wide_sum[W];
        // Overflow occurs when both operands share a sign and the result's sign differs from it.
        of       = (a[W-1] == b[W-1]) && (wide_sum[W-1] != a[W-1]);
        eq       = (a == b);
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// It searches req upward from ptr, wrapping modulo NREQ, and grants the first set bit.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_grant
);

    int slot;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        slot      = 0;
        for (int i = 0; i < NREQ; i++) begin
            slot = (int'(ptr) + i) % NREQ;
            if (!any_grant && req[slot]) begin
                any_grant   = 1'b1;
                grant[slot] = 1'b1;
                idx         = IDW'(slot);
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one adder among NREQ requesters.
// Each result is returned through a one-deep response register tagged with the requester id.
module adder_rr_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = IDW_DEFAULT,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_carry,
    output logic            rsp_of,
    output logic            rsp_eq,
    output logic [CNTW-1:0] op_count
);

    logic [0:0]      state;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            can_issue;
    logic            fire;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    add_result_t     add_res;
    add_result_t     rsp_q;
    logic [IDW-1:0]  id_q;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_grant (pick_any)
    );

    // rsp_ready reaches only the grant path. The response data registers depend on it only through the clock.
    always_comb begin
        can_issue = (state == IDLE) || rsp_ready;
        fire      = can_issue && pick_any;
        req_ready = can_issue ? pick_grant : '0;
        add_a     = '0;
        add_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                add_a = req_a[W*i +: W];
                add_b = req_b[W*i +: W];
            end
        end
    end

    adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .s    (add_res.sum),
        .cary (add_res.carry),
        .of   (add_res.of),
        .eq   (add_res.eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rsp_q    <= '0;
            id_q     <= '0;
            op_count <= '0;
        end else begin
            if (fire) begin
                rsp_q <= add_res;
                id_q  <= pick_idx;
                state <= FULL;
                ptr   <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end else if (state == FULL && rsp_ready) begin
                state <= IDLE;
            end
            if (state == FULL && rsp_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_carry = rsp_q.carry;
    assign rsp_of    = rsp_q.of;
    assign rsp_eq    = rsp_q.eq;

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one combinational 32-bit `adder` instance between NREQ requesters using round-robin arbitration. Each requester has a valid/ready handshake. Results come back through a one-deep registered response port tagged with the requester id. It sits between the operand-producing units and the `adder`, and is the only driver of the adder's a/b inputs.

Parameters:
W, 32, operand width; fixed to match `adder`.
NREQ, 4, number of requesters (2..8).
IDW, 2, id width; must equal clog2(NREQ).
CNTW, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  bit i = requester i has operands.
req_a  in  NREQ*W  packed; slot i = [W*i+W-1:W*i].
req_b  in  NREQ*W  packed, same layout as req_a.
req_ready  out  NREQ  one-hot (or zero) grant; accept when valid&ready.
rsp_valid  out  1  response register holds a result.
rsp_ready  in  1  consumer accepts the response.
rsp_id  out  IDW  index of the granted requester.
rsp_sum  out  W  a+b mod 2^W.
rsp_carry  out  1  carry-out of bit W-1.
rsp_of  out  1  signed two's-complement overflow.
rsp_eq  out  1  adder eq output (a==b), passed through unmodified.
op_count  out  CNTW  completed-operation count.

Behaviour:
- Reset values (asynchronous, immediate on rst):
  - rsp_valid=0; rsp_id, rsp_sum, rsp_carry, rsp_of, rsp_eq = 0.
  - RR pointer=0; op_count=0; state=IDLE.
- States:
  - IDLE: response register empty.
  - FULL: rsp_valid=1, holding a result.
- Grant window: `can_issue = (state==IDLE) | (state==FULL & rsp_ready)`.
  - When can_issue=0, req_ready=0.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at the pointer, ascending, modulo NREQ.
  - The first set bit wins; req_ready carries that single bit.
  - The winner's a/b are muxed onto the adder inputs.
- On a clock edge with a grant:
  - Capture adder s/cary/of/eq and the winner id into the rsp_* registers.
  - rsp_valid=1; state=FULL.
  - pointer = winner+1 (wraps NREQ-1 -> 0).
  - Latency: accept edge -> rsp_valid on that same edge, visible next cycle.
- FULL & rsp_ready & no valid requests: rsp_valid=0, state=IDLE. rsp_* data registers hold their last values.
- FULL & rsp_ready & a request pending: back-to-back reload in that cycle, rsp_valid stays 1. Sustained throughput is 1 op/cycle.
- FULL & !rsp_ready: rsp_* stable, pointer frozen, no grants.
- op_count increments on each response handshake (rsp_valid & rsp_ready) and wraps 2^CNTW-1 -> 0.
- Fairness: a continuously asserted request is granted within NREQ grants.
- Requester protocol:
  - Once valid is asserted it must hold valid and operands until ready.
  - Deasserting valid early is a protocol violation; the bench flags it and the design need not tolerate it.
- Pointer update is unaffected by whether requesters not chosen deassert.
- Reset mid-operation: any held result is discarded; no response is emitted for it after reset releases.
- No combinational path from rsp_ready to rsp_* data; the only combinational path is rsp_ready -> req_ready.

Decomposition:
- Shared include/package `adder_ctrl_pkg`:
  - W=32
  - state encodings IDLE=1'b0, FULL=1'b1
  - default NREQ/IDW.
- Sub-module `rr_pick` (parameter NREQ):
  - inputs: req vector, pointer.
  - outputs: one-hot grant, encoded index, any_grant.
  - purely combinational.
- Top: operand mux, the `adder` instance, response register, FSM, pointer, counter.

Test Plan:
- Reset, then req0 a=5000, b=-5000 with rsp_ready=1: req_ready=0001 in the issue cycle; next cycle rsp_valid=1, rsp_id=0, sum=0, carry=1, of=0, eq=0; op_count=1 after the handshake.
- All four requesting continuously, rsp_ready=1: grant ids 0,1,2,3,0,1 on consecutive cycles, rsp_valid stays high, op_count=6 after six cycles.
- req2 a=b=-2000000000: sum=0x1194D800, carry=1, of=1, eq=1. req3 a=b=2000000000: sum=0xEE6B2800, carry=0, of=1. req1 a=b=0xFFFFFFFF: sum=0xFFFFFFFE, carry=1, of=0, eq=1.
- Backpressure: rsp_ready=0 for 5 cycles with req1 and req2 valid: rsp_* stable, req_ready=0000, pointer frozen. rsp_ready=1 releases req1 first, then req2.
- Reset mid-stream: assert rst while rsp_valid=1 → rsp_valid=0 immediately, op_count=0. First post-reset grant goes to the lowest-index valid requester.
- Counter wrap with CNTW=4: 17 handshakes → op_count=1.
